// File: rtl/fetch_queue.sv
// ============================================================================
// fetch_queue : instruction fetch PC register plus a DEPTH-entry decoupling
//               queue of {instr, pc+4} feeding decode.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    input  logic [31:0]   redirect_pc,
    output logic [31:0]   imem_addr,
    input  logic [31:0]   imem_instr,
    output logic          imem_en,
    input  logic          deq,
    output logic [31:0]   instr_D,
    output logic [31:0]   pc_incr_D,
    output logic          valid_D,
    output logic [AW:0]   count,
    output logic          full
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   mem_instr [DEPTH];
    logic [31:0]   mem_pc    [DEPTH];

    logic          do_deq;
    logic [31:0]   pc_next;

    assign pc_next   = fetch_pc + 32'd4;
    assign imem_addr = fetch_pc;
    assign do_deq    = deq & (count != '0);
    assign imem_en   = !flush & ((count < DEPTH_C) | do_deq);
    assign full      = (count == DEPTH_C);
    assign valid_D   = (count != '0);

    // Head is read purely from registers, so deq/flush never reach instr_D.
    assign instr_D   = valid_D ? mem_instr[rd_ptr] : 32'h0;
    assign pc_incr_D = valid_D ? mem_pc[rd_ptr]    : 32'h0;

    // Storage holds no reset; only the pointers and count qualify its contents.
    always_ff @(posedge clock) begin
        if (imem_en) begin
            mem_instr[wr_ptr] <= imem_instr;
            mem_pc[wr_ptr]    <= pc_next;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            fetch_pc <= 32'h0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (flush) begin
            fetch_pc <= redirect_pc;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (imem_en) begin
                wr_ptr   <= wr_ptr + 1'b1;
                fetch_pc <= pc_next;
            end
            if (do_deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({imem_en, do_deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// tb_fetch_queue : directed self-checking bench for fetch_queue.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        imem_en;
    logic        deq;
    logic [31:0] instr_D;
    logic [31:0] pc_incr_D;
    logic        valid_D;
    logic [2:0]  count;
    logic        full;

    int errors = 0;
    int checks = 0;

    fetch_queue #(.DEPTH(4), .AW(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .redirect_pc(redirect_pc),
        .imem_addr  (imem_addr),
        .imem_instr (imem_instr),
        .imem_en    (imem_en),
        .deq        (deq),
        .instr_D    (instr_D),
        .pc_incr_D  (pc_incr_D),
        .valid_D    (valid_D),
        .count      (count),
        .full       (full)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // Instruction memory model: word content derived from its address.
    assign imem_instr = word(imem_addr);

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; deq = 1'b0; redirect_pc = 32'h0;
        step();
        step();
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got=%h exp=%h", imem_addr, 32'h0); end
        checks++; if (valid_D !== 1'b0)    begin errors++; $display("FAIL rst_valid got=%b exp=0", valid_D); end
        checks++; if (instr_D !== 32'h0)   begin errors++; $display("FAIL rst_instr got=%h exp=0", instr_D); end
        checks++; if (pc_incr_D !== 32'h0) begin errors++; $display("FAIL rst_pcinc got=%h exp=0", pc_incr_D); end
        checks++; if (count !== 3'd0)      begin errors++; $display("FAIL rst_count got=%0d exp=0", count); end
        checks++; if (full !== 1'b0)       begin errors++; $display("FAIL rst_full got=%b exp=0", full); end
        checks++; if (imem_en !== 1'b1)    begin errors++; $display("FAIL rst_en got=%b exp=1", imem_en); end
    endtask

    task automatic test_fill();
        reset = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++; if (count !== 3'(i)) begin errors++; $display("FAIL fill_count%0d got=%0d exp=%0d", i, count, i); end
        end
        checks++; if (full !== 1'b1)        begin errors++; $display("FAIL fill_full got=%b exp=1", full); end
        checks++; if (imem_en !== 1'b0)     begin errors++; $display("FAIL fill_en got=%b exp=0", imem_en); end
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL fill_addr got=%h exp=10", imem_addr); end
        checks++; if (instr_D !== word(32'h0)) begin errors++; $display("FAIL fill_head got=%h exp=%h", instr_D, word(32'h0)); end
        checks++; if (pc_incr_D !== 32'h4)  begin errors++; $display("FAIL fill_pcinc got=%h exp=4", pc_incr_D); end
        step();
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL hold_addr got=%h exp=10", imem_addr); end
        checks++; if (count !== 3'd4)       begin errors++; $display("FAIL hold_count got=%0d exp=4", count); end
    endtask

    task automatic test_full_deq();
        deq = 1'b1;
        #1;
        checks++; if (imem_en !== 1'b1) begin errors++; $display("FAIL fdeq_en got=%b exp=1", imem_en); end
        step();
        deq = 1'b0;
        checks++; if (count !== 3'd4)          begin errors++; $display("FAIL fdeq_count got=%0d exp=4", count); end
        checks++; if (instr_D !== word(32'h4)) begin errors++; $display("FAIL fdeq_head got=%h exp=%h", instr_D, word(32'h4)); end
        checks++; if (pc_incr_D !== 32'h8)     begin errors++; $display("FAIL fdeq_pcinc got=%h exp=8", pc_incr_D); end
        checks++; if (imem_addr !== 32'h14)    begin errors++; $display("FAIL fdeq_addr got=%h exp=14", imem_addr); end
    endtask

    task automatic test_flush();
        // Empty the queue via a redirect to 0x100, then build count=3.
        flush = 1'b1; redirect_pc = 32'h100; deq = 1'b1;
        step();
        flush = 1'b0; deq = 1'b0;
        checks++; if (count !== 3'd0)        begin errors++; $display("FAIL fl0_count got=%0d exp=0", count); end
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL fl0_addr got=%h exp=100", imem_addr); end
        step(); step(); step();
        checks++; if (count !== 3'd3)        begin errors++; $display("FAIL fl_pre_count got=%0d exp=3", count); end
        flush = 1'b1; redirect_pc = 32'h40;
        #1;
        checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL fl_en got=%b exp=0", imem_en); end
        step();
        flush = 1'b0;
        checks++; if (count !== 3'd0)       begin errors++; $display("FAIL fl_count got=%0d exp=0", count); end
        checks++; if (valid_D !== 1'b0)     begin errors++; $display("FAIL fl_valid got=%b exp=0", valid_D); end
        checks++; if (instr_D !== 32'h0)    begin errors++; $display("FAIL fl_instr got=%h exp=0", instr_D); end
        checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL fl_addr got=%h exp=40", imem_addr); end
        step();
        checks++; if (valid_D !== 1'b1)         begin errors++; $display("FAIL fl_tgt_valid got=%b exp=1", valid_D); end
        checks++; if (instr_D !== word(32'h40)) begin errors++; $display("FAIL fl_tgt_instr got=%h exp=%h", instr_D, word(32'h40)); end
        checks++; if (pc_incr_D !== 32'h44)     begin errors++; $display("FAIL fl_tgt_pcinc got=%h exp=44", pc_incr_D); end
    endtask

    task automatic test_reset_midrun();
        step(); step(); step();
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL mid_full got=%b exp=1", full); end
        // Reset must beat both the dequeue and a simultaneous redirect.
        reset = 1'b0; deq = 1'b1; flush = 1'b1; redirect_pc = 32'h80;
        step();
        checks++; if (count !== 3'd0)      begin errors++; $display("FAIL mid_count got=%0d exp=0", count); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL mid_addr got=%h exp=0", imem_addr); end
        checks++; if (valid_D !== 1'b0)    begin errors++; $display("FAIL mid_valid got=%b exp=0", valid_D); end
        reset = 1'b1; deq = 1'b0; flush = 1'b0;
        step();
        checks++; if (count !== 3'd1)          begin errors++; $display("FAIL mid_refill_count got=%0d exp=1", count); end
        checks++; if (instr_D !== word(32'h0)) begin errors++; $display("FAIL mid_refill_instr got=%h exp=%h", instr_D, word(32'h0)); end
        checks++; if (pc_incr_D !== 32'h4)     begin errors++; $display("FAIL mid_refill_pcinc got=%h exp=4", pc_incr_D); end
    endtask

    task automatic test_stream();
        reset = 1'b0; deq = 1'b1;
        step(); step();
        reset = 1'b1;
        #1;
        checks++; if (count !== 3'd0)    begin errors++; $display("FAIL emp_count got=%0d exp=0", count); end
        checks++; if (instr_D !== 32'h0) begin errors++; $display("FAIL emp_instr got=%h exp=0", instr_D); end
        step();
        checks++; if (count !== 3'd1)    begin errors++; $display("FAIL emp_no_uflow got=%0d exp=1", count); end
        for (int k = 0; k < 6; k++) begin
            checks++; if (count !== 3'd1) begin errors++; $display("FAIL str_count%0d got=%0d exp=1", k, count); end
            checks++; if (instr_D !== word(32'(4*k))) begin errors++; $display("FAIL str_instr%0d got=%h exp=%h", k, instr_D, word(32'(4*k))); end
            checks++; if (pc_incr_D !== 32'(4*k+4))   begin errors++; $display("FAIL str_pcinc%0d got=%h exp=%h", k, pc_incr_D, 32'(4*k+4)); end
            step();
        end
        deq = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_deq();
        test_flush();
        test_reset_midrun();
        test_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning queue entries; legal values are powers of two, 2 to 16.
REQ-002 The block SHALL have parameter AW, default 2, meaning pointer width, equal to log2(DEPTH).
REQ-003 The block SHALL have port clock, input, 1, meaning the single rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1, meaning reset: synchronous, active-low.
REQ-005 The block SHALL have port flush, input, 1, meaning redirect request, driven from the memory-stage PCSrc.
REQ-006 The block SHALL have port redirect_pc, input, 32, meaning the new fetch address when flush=1.
REQ-007 The block SHALL have port imem_addr, output, 32, meaning the current fetch PC presented to instruction memory.
REQ-008 The block SHALL have port imem_instr, input, 32, meaning combinational instruction-memory read data for imem_addr.
REQ-009 The block SHALL have port imem_en, output, 1, meaning this cycle's fetch is enqueued at the next edge.
REQ-010 The block SHALL have port deq, input, 1, meaning decode consumes the head entry; tie to !stall_D.
REQ-011 The block SHALL have port instr_D, output, 32, meaning the head instruction.
REQ-012 The block SHALL have port pc_incr_D, output, 32, meaning the head instruction's PC+4.
REQ-013 The block SHALL have port valid_D, output, 1, meaning the head entry is valid.
REQ-014 The block SHALL have port count, output, AW+1, meaning the number of occupied entries.
REQ-015 The block SHALL have port full, output, 1, meaning count==DEPTH.

Function
REQ-016 The block SHALL hold registers fetch_pc[31:0], wr_ptr[AW-1:0], rd_ptr[AW-1:0], count[AW:0] and storage mem[DEPTH] of {instr, pc_incr}.
REQ-017 The block SHALL drive imem_addr = fetch_pc combinationally.
REQ-018 The block SHALL compute do_deq = deq & (count!=0).
REQ-019 The block SHALL compute imem_en = !flush & ((count<DEPTH) | do_deq), combinationally.
REQ-020 On an edge with imem_en=1, the block SHALL write {imem_instr, fetch_pc+4} to mem[wr_ptr], increment wr_ptr modulo DEPTH, and set fetch_pc to fetch_pc+4, with 32-bit wrap-around.
REQ-021 On an edge with do_deq=1 and flush=0, the block SHALL increment rd_ptr modulo DEPTH.
REQ-022 count SHALL be +1 on enqueue only, -1 on dequeue only, and unchanged on simultaneous enqueue and dequeue, including when full.
REQ-023 deq while empty SHALL be ignored: no pointer change and no underflow.
REQ-024 While full with deq=0, imem_en SHALL be 0 and fetch_pc SHALL hold.
REQ-025 flush=1 at an edge SHALL have priority over enqueue and dequeue, and SHALL set fetch_pc=redirect_pc, wr_ptr=rd_ptr=0 and count=0.
REQ-026 Entries SHALL NOT be enqueued in the flush cycle.
REQ-027 The block SHALL drive valid_D = (count!=0), combinationally from registers.
REQ-028 When count!=0, instr_D and pc_incr_D SHALL equal mem[rd_ptr]; otherwise both SHALL be 32'h0, a NOP.
REQ-029 Latency SHALL be one cycle: an instruction fetched in cycle n, with the queue previously empty, appears on instr_D with valid_D=1 in cycle n+1.
REQ-030 After a flush edge, valid_D SHALL be 0 for exactly one cycle, and the redirect target SHALL be valid in the following cycle.
REQ-031 The block SHALL contain no combinational path from deq or flush to instr_D or pc_incr_D.

Reset
REQ-032 When reset=0 at a rising edge, the block SHALL set fetch_pc=0, wr_ptr=0, rd_ptr=0 and count=0; storage contents are don't-care.
REQ-033 While reset=0, outputs SHALL read imem_addr=0, valid_D=0, instr_D=0, pc_incr_D=0, count=0 and full=0 from the first edge onward.
REQ-034 imem_en SHALL evaluate normally from the register values and SHALL have no effect while reset=0.
REQ-035 Reset asserted mid-operation, with a full queue and deq=1, SHALL discard all entries at that edge; reset SHALL have priority over flush.

Verification
REQ-036 Fill: after reset release, with deq=0 and imem_instr=addr-derived pattern -> count=1,2,3,4 over four edges, then full=1, imem_en=0, imem_addr=32'h10 held.
REQ-037 Streaming: with deq=1 continuously -> count=1 steady-state, instr_D matches PCs 0,4,8,... in consecutive cycles and pc_incr_D=PC+4.
REQ-038 Full plus deq: when full=1 and deq=1 for one cycle -> count stays 4, the head advances one entry, and fetch_pc advances by 4.
REQ-039 Flush: with the queue at count=3 and flush=1 with redirect_pc=32'h40 -> next cycle count=0, valid_D=0, imem_addr=32'h40; the following cycle instr_D is the word at 32'h40 and pc_incr_D=32'h44.
REQ-040 Empty deq: with deq=1 held from reset release while the queue is empty -> no underflow, count never exceeds 1, and instr_D=0 whenever valid_D=0.
REQ-041 Reset mid-run: with reset=0 applied while full -> next cycle count=0, imem_addr=0, valid_D=0; after release, refill starts at PC 0.
